add_sub_pipe: RTL and testbench
===============================

# add_sub_pipe

Parametrised, pipelined two's-complement adder/subtractor with a status-flag set and valid/ready handshakes on both sides. Operands are split into CHUNK-bit slices, with one slice resolved per pipeline stage and the carry registered between stages. The block succeeds the fixed 16-bit ripple adder in the arithmetic datapath. It adds subtraction, configurable width and throughput of one operation per clock.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK, ≥ CHUNK.
- CHUNK, 4: bits resolved per stage; STAGES = WIDTH/CHUNK (derived localparam).
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B, 1: A−B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- carry  out  1  carry out of MSB (for subtract: 1 = no borrow).
- overflow  out  1  signed overflow.
- sign  out  1  sum[WIDTH-1].
- zero  out  1  sum == 0.
- parity  out  1  XOR-reduction of sum (1 when the count of ones is odd).

## Operation
- Effective B is `b` XOR {WIDTH{sub}`}`; carry-in to slice 0 is `sub`.
- Stage i (0..STAGES-1) adds slice i of A and effective B with the carry registered by stage i−1. Stage 0 uses `sub` as its carry-in.
- Unresolved operand slices and already-resolved sum slices travel in skew registers with their beat.
- Each stage holds a valid bit.
- Advance enable: adv = !out_valid | out_ready. When adv=1, every stage register loads from its predecessor. When adv=0, all stages hold; there is no partial advance.
- in_ready = adv. A beat is accepted when in_valid & in_ready. A cycle with adv=1 and no accepted beat inserts a bubble (valid=0).
- Last stage: flags are computed from the fully assembled sum and registered together with it.
  - carry = slice carry out of the MSB slice.
  - overflow = (a[MSB] == effB[MSB]) & (sum[MSB] != a[MSB]).
  - sign, zero, parity as defined in the port list.
- Outputs are registered. sum and the flags are stable whenever out_valid=1 and out_ready=0.
- Flags are meaningful only while out_valid=1. They keep their last values during bubbles.

## Timing
- Reset (async assert, sync deassert handled externally): all valid bits are 0, sum=0, and every flag, zero included, is 0. in_ready=1 from the first cycle after reset.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES−1. That is STAGES cycles of register delay; 4 at the defaults.
- Throughput: 1 beat/clock while out_ready=1.
- Capacity: STAGES beats in flight. When out_valid=1 and out_ready=0, in_ready=0 in the same cycle (combinational path out_ready→in_ready is permitted).
- Simultaneous out accept and in accept in the same cycle is allowed, and no beat is lost.
- Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- STAGES=1 (CHUNK=WIDTH) degenerates to a single registered adder with latency 1.

## Structure
- The package add_sub_pkg holds:
  - the flag-vector typedef (carry, overflow, sign, zero, parity), in that order;
  - the default WIDTH/CHUNK constants;
  - a function computing flags from (a_msb, effb_msb, sum, carry).
- Sub-module add_chunk: combinational CHUNK-bit ripple adder (a, b, cin → s, cout), instantiated once per stage via generate.
- The top level contains only the stage registers, the skew registers, the valid chain and the flag registers.

## Test plan
- Defaults, out_ready=1, sub=0, 0x7FFF+0x0001 → after 4 cycles sum=0x8000, overflow=1, sign=1, carry=0, zero=0, parity=1.
- 0xFFFF+0x0001 → sum=0x0000, carry=1, zero=1, overflow=0, sign=0, parity=0.
- sub=1: 0x0005−0x0005 → sum=0, carry=1, zero=1. Then 0x8000−0x0001 → sum=0x7FFF, overflow=1, carry=1, parity=1.
- Stream 8 back-to-back random beats, holding out_ready=0 for 3 cycles mid-stream:
  - in_ready drops in the same cycle that out_valid=1 & out_ready=0;
  - all 8 results arrive in order and match a reference model;
  - sum and flags stay stable while stalled.
- Assert rst_n=0 for 1 cycle with 3 beats in flight → out_valid=0 and all outputs 0 immediately. The next accepted beat has exactly 4-cycle latency.
- WIDTH=32, CHUNK=8: 0x7FFFFFFF+0x00000001 → sum=0x80000000, overflow=1, latency 4. WIDTH=8, CHUNK=8: latency 1.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// The flags helper expects the sum left-aligned in a MAX_WIDTH vector.
package add_sub_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
    localparam int MAX_WIDTH = 256;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic sign;
        logic zero;
        logic parity;
    } flags_t;

    // The sum sits in the top bits and the low bits are zero.
    // That keeps zero and parity exact and puts the sign at MAX_WIDTH-1.
    function automatic flags_t calc_flags(input logic                 a_msb,
                                          input logic                 effb_msb,
                                          input logic [MAX_WIDTH-1:0] sum,
                                          input logic                 carry);
        flags_t f;
        f.carry    = carry;
        f.overflow = (a_msb == effb_msb) && (sum[MAX_WIDTH-1] != a_msb);
        f.sign     = sum[MAX_WIDTH-1];
        f.zero     = (sum == '0);
        f.parity   = ^sum;
        return f;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout
);

    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < CHUNK; i++) begin
            o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor: one CHUNK slice resolved per stage,
// whole-pipe stall on output backpressure, registered result and flags.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             sign,
    output logic             zero,
    output logic             parity
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Handshake: a beat moves on every edge where w_adv=1; the whole pipe
    // holds otherwise. in_ready mirrors w_adv, so in accept = in_valid & w_adv.
    logic                 w_adv;
    logic [WIDTH-1:0]     w_effb;

    logic [STAGES-1:0]    r_valid;
    logic [STAGES-1:0]    r_c;
    logic [WIDTH-1:0]     r_a [STAGES];
    logic [WIDTH-1:0]     r_b [STAGES];
    logic [WIDTH-1:0]     r_s [STAGES];
    flags_t               r_flags;

    logic [STAGES-1:0]    w_v_in;
    logic [STAGES-1:0]    w_cin;
    logic [STAGES-1:0]    w_cout;
    logic [WIDTH-1:0]     w_a_in [STAGES];
    logic [WIDTH-1:0]     w_b_in [STAGES];
    logic [WIDTH-1:0]     w_s_in [STAGES];
    logic [WIDTH-1:0]     w_s_next [STAGES];
    logic [CHUNK-1:0]     w_slice [STAGES];
    logic [MAX_WIDTH-1:0] w_sum_ext;

    assign w_adv    = !r_valid[LAST] || out_ready;
    assign in_ready = w_adv;
    assign w_effb   = b ^ {WIDTH{sub}};

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign w_v_in[gi] = in_valid;
            assign w_a_in[gi] = a;
            assign w_b_in[gi] = w_effb;
            assign w_s_in[gi] = '0;
            assign w_cin[gi]  = sub;
        end else begin : g_next
            assign w_v_in[gi] = r_valid[gi-1];
            assign w_a_in[gi] = r_a[gi-1];
            assign w_b_in[gi] = r_b[gi-1];
            assign w_s_in[gi] = r_s[gi-1];
            assign w_cin[gi]  = r_c[gi-1];
        end

        add_chunk #(.CHUNK(CHUNK)) u_chunk (
            .i_a    (w_a_in[gi][gi*CHUNK +: CHUNK]),
            .i_b    (w_b_in[gi][gi*CHUNK +: CHUNK]),
            .i_cin  (w_cin[gi]),
            .o_s    (w_slice[gi]),
            .o_cout (w_cout[gi])
        );

        // Slices above gi are still zero in the skewed partial sum.
        assign w_s_next[gi] = w_s_in[gi] | (WIDTH'(w_slice[gi]) << (gi * CHUNK));
    end

    assign w_sum_ext = MAX_WIDTH'(w_s_next[LAST]) << (MAX_WIDTH - WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_c     <= '0;
            r_flags <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_s[i] <= '0;
            end
        end else if (w_adv) begin
            r_valid <= w_v_in;
            r_c     <= w_cout;
            for (int i = 0; i < STAGES; i++) begin
                r_a[i] <= w_a_in[i];
                r_b[i] <= w_b_in[i];
                // The output sum only changes on a real beat, never on a bubble.
                if (i != LAST || w_v_in[LAST]) begin
                    r_s[i] <= w_s_next[i];
                end
            end
            if (w_v_in[LAST]) begin
                r_flags <= calc_flags(w_a_in[LAST][WIDTH-1], w_b_in[LAST][WIDTH-1],
                                      w_sum_ext, w_cout[LAST]);
            end
        end
    end

    assign out_valid = r_valid[LAST];
    assign sum       = r_s[LAST];
    assign carry     = r_flags.carry;
    assign overflow  = r_flags.overflow;
    assign sign      = r_flags.sign;
    assign zero      = r_flags.zero;
    assign parity    = r_flags.parity;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: default 16/4 instance checked against an arithmetic
// reference model through an expected-result queue, plus 32/8 and 8/8 instances.
module tb_add_sub_pipe;

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        overflow;
    logic        sign;
    logic        zero;
    logic        parity;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // 16-bit default instance
  logic        in_valid = 1'b0, in_ready, sub = 1'b0, out_valid, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0, sum;
  logic        carry, overflow, sign, zero, parity;

  // 32-bit / CHUNK 8 instance
  logic        in_valid32 = 1'b0, in_ready32, sub32 = 1'b0, out_valid32, out_ready32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        carry32, overflow32, sign32, zero32, parity32;

  // 8-bit / CHUNK 8 instance (single stage)
  logic        in_valid8 = 1'b0, in_ready8, sub8 = 1'b0, out_valid8, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        carry8, overflow8, sign8, zero8, parity8;

  add_sub_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow), .sign(sign), .zero(zero), .parity(parity)
  );

  add_sub_pipe #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .carry(carry32), .overflow(overflow32), .sign(sign32), .zero(zero32),
    .parity(parity32)
  );

  add_sub_pipe #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry(carry8), .overflow(overflow8), .sign(sign8), .zero(zero8),
    .parity(parity8)
  );

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model16(input logic [15:0] op_a, input logic [15:0] op_b,
                                   input logic op_sub);
    exp_t e;
    int   r;
    int   ua, ub;
    ua = int'(op_a);
    ub = int'(op_b);
    if (!op_sub) begin
      e.sum   = 16'((ua + ub) % 65536);
      e.carry = (ua + ub) >= 65536;
      r       = int'($signed(op_a)) + int'($signed(op_b));
    end else begin
      e.sum   = 16'((ua - ub + 65536) % 65536);
      e.carry = (ua >= ub);
      r       = int'($signed(op_a)) - int'($signed(op_b));
    end
    e.overflow = (r > 32767) || (r < -32768);
    e.sign     = (int'(e.sum) >= 32768);
    e.zero     = (e.sum == 16'd0);
    e.parity   = ($countones(e.sum) % 2) == 1;
    return e;
  endfunction

  function automatic logic [63:0] act16();
    exp_t x;
    x.sum = sum; x.carry = carry; x.overflow = overflow;
    x.sign = sign; x.zero = zero; x.parity = parity;
    return 64'(x);
  endfunction

  // Driver: hold the beat until accepted; push the expected result on acceptance.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vs);
    a = va; b = vb; sub = vs; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model16(va, vb, vs));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_timeout", 64'd1, 64'd0);
  endtask

  // Edges from the accepting edge (inclusive) until out_valid is seen; -1 on timeout.
  task automatic measure(input int which, output int lat);
    logic v;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v = (which == 0) ? out_valid : (which == 1) ? out_valid32 : out_valid8;
      if (v) return;
      @(posedge clk);
      lat++;
    end
    lat = -1;
  endtask

  // Monitor: pops on each output transfer; checks stall behaviour.
  logic [63:0] held;
  logic        prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_stable", act16(), held);
      if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
      held       = act16();
      prev_stall = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else check("result", act16(), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #23 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out", {out_valid, act16()[20:0]}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out32", {out_valid32, sum32, carry32, overflow32, sign32, zero32, parity32}, 64'd0);
    check("rst_out8", {out_valid8, sum8, carry8, overflow8, sign8, zero8, parity8}, 64'd0);
    @(posedge clk); #1;

    // Directed vectors; latency on the first
    send(16'h7FFF, 16'h0001, 1'b0);
    measure(0, lat);
    check("latency16", 64'(lat), 64'd4);
    @(posedge clk); #1;
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h0005, 16'h0005, 1'b1);
    send(16'h8000, 16'h0001, 1'b1);
    send(16'h0000, 16'h8000, 1'b1);

    // Random stream with a 3-cycle stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);

    // Reset with 3 beats in flight
    @(posedge clk); #1;
    send(16'h1234, 16'h1111, 1'b0);
    send(16'h4321, 16'h0001, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out", {out_valid, act16()[20:0]}, 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(16'h00FF, 16'h0F01, 1'b0);
    measure(0, lat);
    check("latency_after_rst", 64'(lat), 64'd4);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain2", 64'(exp_q.size()), 64'd0);

    // 32-bit / CHUNK 8
    @(posedge clk); #1;
    a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; sub32 = 1'b0; in_valid32 = 1'b1;
    @(negedge clk);
    check("in_ready32", 64'(in_ready32), 64'd1);
    @(posedge clk); #1 in_valid32 = 1'b0;
    measure(1, lat);
    check("latency32", 64'(lat), 64'd4);
    check("sum32", 64'(sum32), 64'(a32 + b32));
    check("ovf32_sign32", {overflow32, sign32, carry32}, 64'b110);

    // 8-bit single stage
    @(posedge clk); #1;
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    check("in_ready8", 64'(in_ready8), 64'd1);
    @(posedge clk); #1 in_valid8 = 1'b0;
    measure(2, lat);
    check("latency8", 64'(lat), 64'd1);
    check("sum8", {sum8, carry8, overflow8, sign8, zero8, parity8}, {8'h80, 5'b01101});
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1 in_valid8 = 1'b0;
    @(negedge clk);
    check("sub8", {out_valid8, sum8, carry8, overflow8, sign8, zero8, parity8},
          {1'b1, 8'hF0, 5'b00100});

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
